multicycle_control_fsm: RTL

Multicycle sequencer for the ARM-subset processor. It replaces the single-cycle control unit when the datapath shares one memory and one ALU across cycles. It decodes the latched instruction fields, evaluates the condition field against an internal NZCV register, and steps a Moore FSM. Each step drives the datapath enables and muxes for one micro-operation.

---
 rtl/multicycle_control_fsm.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the ARM-subset core: decodes the latched
// instruction, tracks NZCV, and steps a Moore FSM that drives the datapath controls.
module multicycle_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_control,
    output logic [3:0] state,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_nzcv;

    logic [3:0] w_cmd;
    logic       w_i_bit;
    logic       w_s_bit;
    logic       w_is_cmp;
    logic       w_rd_pc;
    logic [3:0] w_cmd_alu;
    logic       w_cmd_valid;
    logic       w_cmd_logic;
    logic       w_cond_ex;
    logic       w_flag_load;
    logic       w_n, w_z, w_c, w_v;

    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    logic [3:0] w_alu_control;
    logic       w_instr_done;

    assign w_i_bit  = funct[5];
    assign w_cmd    = funct[4:1];
    assign w_s_bit  = funct[0];
    assign w_is_cmp = (w_cmd == 4'b1010);
    assign w_rd_pc  = (rd == 4'd15);

    assign {w_n, w_z, w_c, w_v} = r_nzcv;

    // Logical ops only produce meaningful N/Z; C/V must survive them.
    always_comb begin
        w_cmd_alu   = 4'b0000;
        w_cmd_valid = 1'b1;
        w_cmd_logic = 1'b0;
        case (w_cmd)
            4'b0100: w_cmd_alu = 4'b0000;
            4'b0010: w_cmd_alu = 4'b0001;
            4'b1010: w_cmd_alu = 4'b0001;
            4'b0000: begin w_cmd_alu = 4'b0010; w_cmd_logic = 1'b1; end
            4'b1100: begin w_cmd_alu = 4'b0011; w_cmd_logic = 1'b1; end
            4'b0001: begin w_cmd_alu = 4'b0100; w_cmd_logic = 1'b1; end
            4'b1101: begin w_cmd_alu = 4'b0101; w_cmd_logic = 1'b1; end
            default: w_cmd_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_cond_ex = 1'b0;
        case (cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_load = ((r_state == S_EXECR) || (r_state == S_EXECI)) &&
                         (w_s_bit || w_is_cmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv <= 4'b0000;
        end else if (w_flag_load) begin
            r_nzcv[3:2] <= alu_flags[3:2];
            if (!w_cmd_logic) begin
                r_nzcv[1:0] <= alu_flags[1:0];
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_alu_control = 4'b0000;
        w_instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (!w_cond_ex || op == 2'b11) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else begin
                    case (op)
                        2'b00:   w_next = w_i_bit ? S_EXECI : S_EXECR;
                        2'b01:   w_next = S_MEMADR;
                        default: w_next = S_BRANCH;
                    endcase
                end
            end
            S_MEMADR: begin
                w_alu_src_b = 2'b01;
                w_next      = w_s_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_pc_write   = w_rd_pc;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                w_alu_src_b   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_alu_control = w_cmd_alu;
                if (w_is_cmp) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else begin
                    w_next = S_ALUWB;
                end
            end
            S_ALUWB: begin
                w_reg_write  = w_cmd_valid;
                w_pc_write   = w_rd_pc;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_b  = 2'b01;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks every control combinationally so no enable can pulse while held.
    assign pc_write    = rst_n & w_pc_write;
    assign adr_src     = rst_n & w_adr_src;
    assign mem_write   = rst_n & w_mem_write;
    assign ir_write    = rst_n & w_ir_write;
    assign reg_write   = rst_n & w_reg_write;
    assign alu_src_a   = rst_n & w_alu_src_a;
    assign alu_src_b   = {2{rst_n}} & w_alu_src_b;
    assign result_src  = {2{rst_n}} & w_result_src;
    assign alu_control = {4{rst_n}} & w_alu_control;
    assign instr_done  = rst_n & w_instr_done;
    assign state       = r_state;

endmodule
